param_ring_counter: RTL and testbench
=====================================

// Module: param_ring_counter
// PURPOSE
//  Parametrised successor to the fixed 8-bit one-hot ring counter in the tt_um top.
//  Generalised in width and seed; adds Johnson and bounce modes, direction control,
//  parallel load, a period-wrap pulse and one-hot self-correction.
//  Drives uo_out (LED/phase-select patterns) from the TinyTapeout wrapper.
// PARAMETERS
//  WIDTH   8      register width, >=3
//  SEED    1      reset/recovery pattern; must be one-hot for RING/BOUNCE use
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      synchronous reset, active-high
//  en        in   1      step enable; 0 = hold all state
//  mode      in   2      00 RING, 01 JOHNSON, 10 BOUNCE, 11 HOLD
//  dir       in   1      0 = shift toward MSB (left), 1 = toward LSB (right)
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value loaded when load=1
//  q         out  WIDTH  counter state (registered)
//  pos       out  PW     step index within current period, PW=$clog2(2*WIDTH)
//  wrap      out  1      1-cycle pulse: pos returned to 0 on this edge
//  err       out  1      1-cycle pulse: illegal one-hot state corrected
// BEHAVIOUR
//  Reset (rst=1 at edge): q=SEED, pos=0, wrap=0, err=0, bdir=dir. Overrides all.
//  Priority per edge: rst > load > en step > hold. Latency 1 cycle for every action.
//  load=1: q=load_val, pos=0, wrap=0, err=0 (no legality check on load edge).
//  en=0 and load=0: q, pos held; wrap=0, err=0.
//  Step (en=1, load=0), by mode:
//   RING:    left q={q[W-2:0],q[W-1]}; right q={q[0],q[W-1:1]}. Period W.
//   JOHNSON: left q={q[W-2:0],~q[W-1]}; right q={~q[0],q[W-1:1]}. Period 2W.
//   BOUNCE:  one-hot moves one bit in internal bdir; bdir flips when step lands on
//            bit W-1 (moving left) or bit 0 (moving right). Period 2W-2.
//            bdir loads from dir on rst, load, and on entering BOUNCE.
//   HOLD:    q, pos held; wrap=0, err=0 (en ignored).
//  pos: increments on each step; when pos==period-1 it becomes 0 and wrap=1.
//  Self-correct (RING/BOUNCE only): if q is not one-hot (popcount!=1) at a step edge,
//   q=SEED, pos=0, err=1, wrap=0 instead of shifting. JOHNSON never asserts err.
//  Mode change: sampled every edge; on any edge where mode differs from last-step
//   mode, pos=0 before the step is applied (that step makes pos=1). No wrap on change.
//  dir change in RING/JOHNSON takes effect on the same edge; pos continues counting.
//  wrap and err are mutually exclusive; both registered, never combinational.
// STRUCTURE
//  Package ringctr_pkg: mode localparams MODE_RING/JOHNSON/BOUNCE/HOLD (2-bit),
//   function period(mode,WIDTH) returning W / 2W / 2W-2.
//  Sub-module onehot_check #(WIDTH): combinational, out=1 iff popcount(in)==1.
//  Top: q/pos/bdir/last_mode registers, one next-state case on mode.
// TESTING  (WIDTH=8, SEED=8'h01)
//  rst 1 cycle, RING, dir=0, en=1 x8 -> q 02,04,..,80,01; wrap=1 only on 8th edge.
//  RING dir=1 from 01 -> 80,40; load=1 load_val=8'h24 -> next q=24, pos=0, then
//   step -> q=01, err=1, pos=0.
//  JOHNSON dir=0 from 00 (load) x16 -> 01,03,07,..,FF,FE,..,80,00; wrap on edge 16.
//  BOUNCE from 01, dir=0 x14 -> 02..80,40..01; wrap on edge 14; bdir flips at 80.
//  en=0 or mode=HOLD for 5 cycles mid-sequence -> q, pos frozen, wrap/err stay 0.
//  rst asserted mid-JOHNSON with load=1 same edge -> q=01, pos=0 (rst wins).

Source files
------------

// File: rtl/ringctr_pkg.sv
// rtl/ringctr_pkg.sv - mode encodings and per-mode period helper for the ring counter
package ringctr_pkg;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  function automatic int period(input logic [1:0] m, input int w);
    case (m)
      MODE_JOHNSON: return 2 * w;
      MODE_BOUNCE:  return 2 * w - 2;
      default:      return w;
    endcase
  endfunction

endpackage

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - combinational flag, high iff exactly one bit of the input is set
module onehot_check #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign out = (in != '0) && ((in & (in - WIDTH'(1))) == '0);

endmodule

// File: rtl/param_ring_counter.sv
// rtl/param_ring_counter.sv - ring/Johnson/bounce counter with load, wrap pulse and one-hot recovery
module param_ring_counter
  import ringctr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  localparam int              PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);

  logic             bdir, bdir_n;
  logic [1:0]       last_mode, last_mode_n;
  logic [WIDTH-1:0] q_n;
  logic [PW-1:0]    pos_n, pos_base, per_m1;
  logic             wrap_n, err_n;
  logic             mode_chg, q_onehot, bd;

  onehot_check #(.WIDTH(WIDTH)) u_onehot (
    .in  (q),
    .out (q_onehot)
  );

  assign per_m1   = PW'(period(mode, WIDTH) - 1);
  assign mode_chg = (mode != last_mode);
  assign pos_base = mode_chg ? '0 : pos;

  always_comb begin
    q_n         = q;
    pos_n       = pos;
    bdir_n      = bdir;
    last_mode_n = last_mode;
    wrap_n      = 1'b0;
    err_n       = 1'b0;
    bd          = mode_chg ? dir : bdir;
    if (load) begin
      q_n    = load_val;
      pos_n  = '0;
      bdir_n = dir;
    end else if (en && mode != MODE_HOLD) begin
      last_mode_n = mode;
      if (pos_base == per_m1) begin
        pos_n  = '0;
        wrap_n = 1'b1;
      end else begin
        pos_n = pos_base + PW'(1);
      end
      case (mode)
        MODE_RING:    q_n = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_JOHNSON: q_n = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
        MODE_BOUNCE: begin
          // A bit already parked at an end reverses before moving so it never falls off.
          if (!bd && q[WIDTH-1])
            bd = 1'b1;
          else if (bd && q[0])
            bd = 1'b0;
          q_n    = bd ? (q >> 1) : (q << 1);
          bdir_n = bd;
          if (!bd && q_n[WIDTH-1])
            bdir_n = 1'b1;
          else if (bd && q_n[0])
            bdir_n = 1'b0;
        end
        default: ;
      endcase
      if (mode != MODE_JOHNSON && !q_onehot) begin
        q_n    = SEED;
        pos_n  = '0;
        wrap_n = 1'b0;
        err_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= SEED;
      pos       <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      bdir      <= dir;
      last_mode <= mode;
    end else begin
      q         <= q_n;
      pos       <= pos_n;
      wrap      <= wrap_n;
      err       <= err_n;
      bdir      <= bdir_n;
      last_mode <= last_mode_n;
    end
  end

endmodule

// File: tb/tb_param_ring_counter.sv
// tb/tb_param_ring_counter.sv - directed vector bench for param_ring_counter (WIDTH=8, SEED=01)
module tb_param_ring_counter;

  localparam logic [1:0] RING = 2'b00, JOHN = 2'b01, BNC = 2'b10, HOLD = 2'b11;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic [3:0] pos;
    logic       wrap;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [1:0] mode;
  logic [7:0] load_val;
  logic [7:0] q;
  logic [3:0] pos;
  logic       wrap, err;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  param_ring_counter #(.WIDTH(8), .SEED(8'h01)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .pos      (pos),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic d,
                     input logic l, input logic [7:0] lv, input logic [7:0] eq,
                     input logic [3:0] ep, input logic ew, input logic ee);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.dir = d; v.load = l; v.load_val = lv;
    v.q = eq; v.pos = ep; v.wrap = ew; v.err = ee;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; en = v.en; mode = v.mode; dir = v.dir; load = v.load; load_val = v.load_val;
    @(posedge clk);
    #1;
    n_vec++;
    if (q !== v.q || pos !== v.pos || wrap !== v.wrap || err !== v.err) begin
      n_bad++;
      $display("FAIL vec%0d: got q=%h pos=%0d wrap=%b err=%b, expected q=%h pos=%0d wrap=%b err=%b",
               idx, q, pos, wrap, err, v.q, v.pos, v.wrap, v.err);
    end
  endtask

  initial begin
    logic [7:0] exp_q;
    rst = 1'b1; en = 1'b0; mode = RING; dir = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset, then RING left through one full period.
    add(1, 0, RING, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    exp_q = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      exp_q = {exp_q[6:0], exp_q[7]};
      add(0, 1, RING, 0, 0, 8'h00, exp_q, 4'(i % 8), i == 8, 0);
    end
    // RING right, then load a non-one-hot value and let the step correct it.
    add(0, 1, RING, 1, 0, 8'h00, 8'h80, 1, 0, 0);
    add(0, 1, RING, 1, 0, 8'h00, 8'h40, 2, 0, 0);
    add(0, 1, RING, 1, 1, 8'h24, 8'h24, 0, 0, 0);
    add(0, 1, RING, 1, 0, 8'h00, 8'h01, 0, 0, 1);
    add(0, 1, RING, 1, 0, 8'h00, 8'h80, 1, 0, 0);
    // Freeze via en=0 then via HOLD; resuming RING continues the count.
    for (int i = 0; i < 5; i++) add(0, 0, RING, 1, 0, 8'h00, 8'h80, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, HOLD, 1, 0, 8'h00, 8'h80, 1, 0, 0);
    add(0, 1, RING, 1, 0, 8'h00, 8'h40, 2, 0, 0);
    // JOHNSON from 00 across its 16-step period.
    add(0, 1, JOHN, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    exp_q = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      exp_q = {exp_q[6:0], ~exp_q[7]};
      add(0, 1, JOHN, 0, 0, 8'h00, exp_q, 4'(i % 16), i == 16, 0);
    end
    add(0, 1, JOHN, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    add(0, 1, JOHN, 0, 0, 8'h00, 8'h03, 2, 0, 0);
    // Reset and load on the same edge: reset wins.
    add(1, 1, JOHN, 0, 1, 8'hFF, 8'h01, 0, 0, 0);
    // BOUNCE over its 14-step period, then dir is ignored while bouncing.
    add(0, 1, BNC, 0, 0, 8'h00, 8'h02, 1, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h04, 2, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h08, 3, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h10, 4, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h20, 5, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h40, 6, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h80, 7, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h40, 8, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h20, 9, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h10, 10, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h08, 11, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h04, 12, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h02, 13, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h01, 0, 1, 0);
    add(0, 1, BNC, 1, 0, 8'h00, 8'h02, 1, 0, 0);
    add(0, 1, BNC, 1, 0, 8'h00, 8'h04, 2, 0, 0);
    // BOUNCE self-correction, and load taking priority over a disabled step.
    add(0, 1, BNC, 0, 1, 8'h03, 8'h03, 0, 0, 0);
    add(0, 1, BNC, 0, 0, 8'h00, 8'h01, 0, 0, 1);
    add(0, 0, BNC, 0, 1, 8'h10, 8'h10, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: RING dir flips mid-stream take effect on the same edge.
    begin
      vec_t v;
      v.rst = 1; v.en = 0; v.mode = RING; v.dir = 0; v.load = 0; v.load_val = 8'h00;
      v.q = 8'h01; v.pos = 0; v.wrap = 0; v.err = 0;
      apply(v, 1000);
      v.rst = 0; v.en = 1; v.q = 8'h02; v.pos = 1;
      apply(v, 1001);
      v.dir = 1; v.q = 8'h01; v.pos = 2;
      apply(v, 1002);
      v.q = 8'h80; v.pos = 3;
      apply(v, 1003);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
